// File: rtl/ov7725_page_buf_pkg.sv
// ov7725_flash_pkg: constants and types shared by the OV7725 capture to SPI
// flash path.
//   PAGE_BYTES / PAGES_PER_FRAME : flash page geometry for one 640x480 frame
//   BYTE_W / PAGE_W / PIX_W      : byte-index, page-index and pixel widths
//   wr_state_e                   : page buffer write-side FSM encoding
//   FLASH_OP_PAGE_PROGRAM        : SPI flash Page Program opcode
//   sat_inc16                    : saturating 16-bit increment
package ov7725_flash_pkg;

    localparam int PAGE_BYTES      = 256;
    localparam int PAGES_PER_FRAME = 1200;
    localparam int BYTE_W          = 8;
    localparam int PAGE_W          = 11;
    localparam int PIX_W           = 8;

    typedef enum logic [1:0] {
        WR_IDLE = 2'b00,
        WR_FILL = 2'b01,
        WR_DONE = 2'b10
    } wr_state_e;

    localparam logic [7:0] FLASH_OP_PAGE_PROGRAM = 8'h02;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/ov7725_page_buf_if.sv
// ov7725_page_buf_if: pixel stream in, flash page drain out.
//   pix_valid/pixel          : capture-side byte stream
//   page_ready/page_idx      : drain-side page full, frame-relative index
//   rd_en/rd_data/rd_valid   : byte read handshake, one cycle latency
//   page_release             : drained page programmed, free it
// master = producer of pixels and drain requests, slave = the page buffer.
interface ov7725_page_buf_if;

    logic                                   pix_valid;
    logic [ov7725_flash_pkg::PIX_W-1:0]     pixel;
    logic                                   page_ready;
    logic [ov7725_flash_pkg::PAGE_W-1:0]    page_idx;
    logic                                   rd_en;
    logic [ov7725_flash_pkg::PIX_W-1:0]     rd_data;
    logic                                   rd_valid;
    logic                                   page_release;

    modport master (
        output pix_valid, pixel, rd_en, page_release,
        input  page_ready, page_idx, rd_data, rd_valid
    );

    modport slave (
        input  pix_valid, pixel, rd_en, page_release,
        output page_ready, page_idx, rd_data, rd_valid
    );

endinterface

// File: rtl/ov7725_page_buf_ram.sv
// page_buf_ram: 512x8 simple dual-port RAM holding both pages.
//   clk24M       : clock
//   rst          : synchronous active-high reset of the read register only
//   we/waddr/wdata : write port
//   re/raddr/rdata : registered read port (data valid the cycle after re)
module page_buf_ram (
    input  logic       clk24M,
    input  logic       rst,
    input  logic       we,
    input  logic [8:0] waddr,
    input  logic [7:0] wdata,
    input  logic       re,
    input  logic [8:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem_r [0:511];

    // write port
    always_ff @(posedge clk24M) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // registered read port; only the output register is reset so the array maps to block RAM
    always_ff @(posedge clk24M) begin
        if (rst) begin
            rdata <= 8'h00;
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/ov7725_page_buf.sv
// ov7725_page_buf: ping-pong page buffer between the OV7725 grayscale
// capture path and the SPI flash page-program sequencer.
//   clk24M      : sole clock
//   rst         : synchronous active-high reset
//   frame_start : pulse, starts or restarts a frame
//   bus         : ov7725_page_buf_if.slave (pixel stream + page drain)
//   frame_done  : pulse the cycle after the last page of the frame is released
//   busy        : write side in FILL or DONE
//   ovf         : sticky, a byte was dropped this frame
//   drop_cnt    : saturating drop counter, only with OV7725_PAGE_BUF_DROP_CNT_EN
module ov7725_page_buf #(
    parameter int PAGE_BYTES      = ov7725_flash_pkg::PAGE_BYTES,
    parameter int PAGES_PER_FRAME = ov7725_flash_pkg::PAGES_PER_FRAME
) (
    input  logic                   clk24M,
    input  logic                   rst,
    input  logic                   frame_start,
    ov7725_page_buf_if.slave       bus,
    output logic                   frame_done,
    output logic                   busy,
`ifdef OV7725_PAGE_BUF_DROP_CNT_EN
    output logic [15:0]            drop_cnt,
`endif
    output logic                   ovf
);

    import ov7725_flash_pkg::*;

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(PAGE_BYTES - 1);
    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(PAGES_PER_FRAME - 1);

    wr_state_e          state_r;
    logic [1:0]         full_r;
    logic               wbuf_r;
    logic               rbuf_r;
    logic [BYTE_W-1:0]  wbyte_r;
    logic [BYTE_W-1:0]  rbyte_r;
    logic [PAGE_W-1:0]  wr_page_r;
    logic [PAGE_W-1:0]  rd_page_r;
    logic               ovf_r;
    logic               frame_done_r;
    logic               rd_valid_r;

    logic               filling_s;
    logic               wr_s;
    logic               drop_s;
    logic               page_done_s;
    logic               rd_s;
    logic               rel_s;
    logic               last_rel_s;
    logic [1:0]         set_mask_s;
    logic [1:0]         clr_mask_s;

    // frame_start has priority over any write or drop in the same cycle
    assign filling_s   = (state_r == WR_FILL) && !frame_start;
    assign wr_s        = filling_s && bus.pix_valid && !full_r[wbuf_r];
    assign drop_s      = filling_s && bus.pix_valid &&  full_r[wbuf_r];
    assign page_done_s = wr_s && (wbyte_r == LAST_BYTE);
    assign rd_s        = bus.rd_en && full_r[rbuf_r];
    assign rel_s       = bus.page_release && full_r[rbuf_r];
    assign last_rel_s  = rel_s && (state_r == WR_DONE) && (rd_page_r == LAST_PAGE);

    // fill and release always hit different buffers, so set and clear never collide
    assign set_mask_s  = page_done_s ? (wbuf_r ? 2'b10 : 2'b01) : 2'b00;
    assign clr_mask_s  = rel_s       ? (rbuf_r ? 2'b10 : 2'b01) : 2'b00;

    page_buf_ram u_ram (
        .clk24M (clk24M),
        .rst    (rst),
        .we     (wr_s),
        .waddr  ({wbuf_r, wbyte_r}),
        .wdata  (bus.pixel),
        .re     (rd_s),
        .raddr  ({rbuf_r, rbyte_r}),
        .rdata  (bus.rd_data)
    );

    // write-side FSM, buffer full flags and drain pointers
    always_ff @(posedge clk24M) begin
        if (rst) begin
            state_r      <= WR_IDLE;
            full_r       <= 2'b00;
            wbuf_r       <= 1'b0;
            rbuf_r       <= 1'b0;
            wbyte_r      <= '0;
            rbyte_r      <= '0;
            wr_page_r    <= '0;
            rd_page_r    <= '0;
            ovf_r        <= 1'b0;
            frame_done_r <= 1'b0;
            rd_valid_r   <= 1'b0;
        end else begin
            // an accepted read always completes, even across a restart
            rd_valid_r <= rd_s;
            if (frame_start) begin
                state_r      <= WR_FILL;
                full_r       <= 2'b00;
                wbuf_r       <= 1'b0;
                rbuf_r       <= 1'b0;
                wbyte_r      <= '0;
                rbyte_r      <= '0;
                wr_page_r    <= '0;
                rd_page_r    <= '0;
                ovf_r        <= 1'b0;
                frame_done_r <= 1'b0;
            end else begin
                frame_done_r <= last_rel_s;
                full_r       <= (full_r | set_mask_s) & ~clr_mask_s;

                case (state_r)
                    WR_IDLE: state_r <= WR_IDLE;
                    WR_FILL: begin
                        if (page_done_s && (wr_page_r == LAST_PAGE)) begin
                            state_r <= WR_DONE;
                        end
                    end
                    WR_DONE: begin
                        if (last_rel_s) begin
                            state_r <= WR_IDLE;
                        end
                    end
                    default: state_r <= WR_IDLE;
                endcase

                if (wr_s) begin
                    if (page_done_s) begin
                        wbyte_r   <= '0;
                        wbuf_r    <= ~wbuf_r;
                        wr_page_r <= wr_page_r + 11'd1;
                    end else begin
                        wbyte_r   <= wbyte_r + 8'd1;
                    end
                end

                if (drop_s) begin
                    ovf_r <= 1'b1;
                end

                // the read in a release cycle already used the old pointers
                if (rel_s) begin
                    rbuf_r    <= ~rbuf_r;
                    rbyte_r   <= '0;
                    rd_page_r <= rd_page_r + 11'd1;
                end else if (rd_s) begin
                    rbyte_r   <= rbyte_r + 8'd1;
                end
            end
        end
    end

`ifdef OV7725_PAGE_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // saturating count of dropped bytes for the current frame
    always_ff @(posedge clk24M) begin
        if (rst || frame_start) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s) begin
            drop_cnt_r <= sat_inc16(drop_cnt_r);
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

    assign bus.page_ready = full_r[rbuf_r];
    assign bus.page_idx   = rd_page_r;
    assign bus.rd_valid   = rd_valid_r;
    assign frame_done     = frame_done_r;
    assign busy           = (state_r != WR_IDLE);
    assign ovf            = ovf_r;

endmodule

// File: tb/tb_ov7725_page_buf.sv
// Directed self-checking bench for ov7725_page_buf. The frame length is
// shortened to NPG pages so a complete frame fits a short run.
module tb_ov7725_page_buf;

    localparam int NPG = 8;

    logic clk24M = 1'b0;
    logic rst = 1'b0;
    logic frame_start = 1'b0;
    logic frame_done;
    logic busy;
    logic ovf;
`ifdef OV7725_PAGE_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int total = 0;
    int bad = 0;

    ov7725_page_buf_if bus ();

    ov7725_page_buf #(
        .PAGE_BYTES      (256),
        .PAGES_PER_FRAME (NPG)
    ) dut (
        .clk24M      (clk24M),
        .rst         (rst),
        .frame_start (frame_start),
        .bus         (bus),
        .frame_done  (frame_done),
        .busy        (busy),
`ifdef OV7725_PAGE_BUF_DROP_CNT_EN
        .drop_cnt    (drop_cnt),
`endif
        .ovf         (ovf)
    );

    always #5 clk24M = ~clk24M;

    task automatic tick();
        @(posedge clk24M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // n pixels with values first, first+1, ... (mod 256)
    task automatic wr_bytes(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            bus.pix_valid = 1'b1;
            bus.pixel     = 8'(first + i);
            tick();
        end
        bus.pix_valid = 1'b0;
    endtask

    // n reads, each expected to return base+i one cycle later
    task automatic rd_chk(input string tag, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.rd_en = 1'b1;
            tick();
            chk(tag, {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, 8'(base + i)});
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic release_page();
        bus.page_release = 1'b1;
        tick();
        bus.page_release = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.page_ready), 32'd0);
        chk({tag, "_idx"},   32'(bus.page_idx),   32'd0);
        chk({tag, "_rvld"},  32'(bus.rd_valid),   32'd0);
        chk({tag, "_rdata"}, 32'(bus.rd_data),    32'd0);
        chk({tag, "_done"},  32'(frame_done),     32'd0);
        chk({tag, "_busy"},  32'(busy),           32'd0);
        chk({tag, "_ovf"},   32'(ovf),            32'd0);
`ifdef OV7725_PAGE_BUF_DROP_CNT_EN
        chk({tag, "_dcnt"},  32'(drop_cnt),       32'd0);
`endif
    endtask

    initial begin
        bus.pix_valid    = 1'b0;
        bus.pixel        = 8'h00;
        bus.rd_en        = 1'b0;
        bus.page_release = 1'b0;

        // reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // read request with nothing ready
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("idle_rd_no_valid", 32'(bus.rd_valid), 32'd0);

        // single page
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        wr_bytes(0, 255);
        chk("t1_not_ready_255", 32'(bus.page_ready), 32'd0);
        wr_bytes(255, 1);
        chk("t1_ready", 32'(bus.page_ready), 32'd1);
        chk("t1_idx", 32'(bus.page_idx), 32'd0);
        rd_chk("t1_rd", 0, 256);
        tick();
        chk("t1_rvld_one_cycle", 32'(bus.rd_valid), 32'd0);
        release_page();
        chk("t1_rel_ready", 32'(bus.page_ready), 32'd0);
        chk("t1_rel_idx", 32'(bus.page_idx), 32'd1);

        // overflow: both pages full, three more bytes dropped
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t2_restart_idx", 32'(bus.page_idx), 32'd0);
        wr_bytes(0, 256);
        wr_bytes(100, 256);
        chk("t2_no_ovf_yet", 32'(ovf), 32'd0);
        wr_bytes(224, 3);
        chk("t2_ovf", 32'(ovf), 32'd1);
`ifdef OV7725_PAGE_BUF_DROP_CNT_EN
        chk("t2_drop_cnt", 32'(drop_cnt), 32'd3);
`endif
        rd_chk("t2_page0", 0, 256);
        release_page();
        chk("t2_p1_ready", 32'(bus.page_ready), 32'd1);
        chk("t2_p1_idx", 32'(bus.page_idx), 32'd1);
        rd_chk("t2_page1", 100, 256);
        release_page();
        chk("t2_empty", 32'(bus.page_ready), 32'd0);
        wr_bytes(50, 255);
        chk("t2_drop_no_advance", 32'(bus.page_ready), 32'd0);
        wr_bytes(305, 1);
        chk("t2_p2_ready", 32'(bus.page_ready), 32'd1);
        chk("t2_p2_idx", 32'(bus.page_idx), 32'd2);
        rd_chk("t2_page2", 50, 2);

        // full frame, concurrent fill/drain, release coincident with page completion
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int p = 0; p <= NPG; p++) begin
            for (int c = 0; c < 256; c++) begin
                bus.pix_valid    = (p < NPG);
                bus.pixel        = 8'(p * 7 + c);
                bus.rd_en        = (p >= 1);
                bus.page_release = (p >= 1) && (c == 255);
                if (p >= 1 && c == 0) begin
                    chk("t3_page_idx", 32'(bus.page_idx), 32'(p - 1));
                end
                if (p == NPG && c == 0) begin
                    chk("t3_busy_done", 32'(busy), 32'd1);
                end
                tick();
                if (p >= 1) begin
                    chk("t3_rd", {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, 8'((p - 1) * 7 + c)});
                end
                if (p >= 1 && p < NPG && c == 255) begin
                    chk("t4_simul", {20'd0, bus.page_ready, bus.page_idx}, {20'd0, 1'b1, 11'(p)});
                end
                if (p < NPG && c < 255) begin
                    chk("t3_no_done", 32'(frame_done), 32'd0);
                end
            end
        end
        bus.pix_valid    = 1'b0;
        bus.rd_en        = 1'b0;
        bus.page_release = 1'b0;
        chk("t3_frame_done", 32'(frame_done), 32'd1);
        chk("t3_idle", 32'(busy), 32'd0);
        chk("t3_empty", 32'(bus.page_ready), 32'd0);
        tick();
        chk("t3_done_pulse", 32'(frame_done), 32'd0);

        // abort mid-page 5
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int p = 0; p < 5; p++) begin
            wr_bytes(p * 3, 256);
            if (p < 4) begin
                release_page();
            end
        end
        chk("t5_p4_ready", 32'(bus.page_ready), 32'd1);
        chk("t5_p4_idx", 32'(bus.page_idx), 32'd4);
        wr_bytes(9, 100);
        rd_chk("t5_p4_rd", 12, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t5_abort_ready", 32'(bus.page_ready), 32'd0);
        chk("t5_abort_idx", 32'(bus.page_idx), 32'd0);
        chk("t5_abort_busy", 32'(busy), 32'd1);
        chk("t5_abort_rvld", 32'(bus.rd_valid), 32'd0);
        wr_bytes(200, 256);
        chk("t5_new_ready", 32'(bus.page_ready), 32'd1);
        chk("t5_new_idx", 32'(bus.page_idx), 32'd0);
        rd_chk("t5_new_rd", 200, 1);

        // reset mid-frame after an overflow
        wr_bytes(0, 256);
        wr_bytes(0, 2);
        chk("t5_pre_rst_ovf", 32'(ovf), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("t5_rst");
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("t5_rd_no_ready", 32'(bus.rd_valid), 32'd0);
        tick();
        chk("t5_no_frame_done", 32'(frame_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
